// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between the I-cache and D-cache controllers.
// Round-robin grant, latched command, bus-hang timeout and sticky error.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 256,
    parameter int TO_WIDTH   = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd0,
    input  logic                  wr0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  ready0,
    input  logic                  rd1,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ready1,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  owner,
    output logic                  timeout_err,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } state_t;

    state_t                state_q;
    logic                  prio_q;
    logic [TO_WIDTH-1:0]   cnt_q;

    logic                  req0_d;
    logic                  req1_d;
    logic                  gnt_d;
    logic                  to_hit_d;
    logic [DATA_WIDTH-1:0] ret_d;

    always_comb begin
        req0_d   = rd0 | wr0;
        req1_d   = rd1 | wr1;
        gnt_d    = (req0_d & req1_d) ? prio_q : req1_d;
        to_hit_d = (TIMEOUT != 0) && (cnt_q == TO_WIDTH'(TIMEOUT - 1));
        // a real completion beats a timeout firing in the same cycle
        ret_d    = mem_ready ? mem_rdata : '1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
            ready0      <= 1'b0;
            ready1      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            owner       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (req0_d | req1_d) begin
                        owner     <= gnt_d;
                        mem_addr  <= gnt_d ? addr1 : addr0;
                        mem_wdata <= gnt_d ? wdata1 : wdata0;
                        mem_wr    <= gnt_d ? wr1 : wr0;
                        mem_rd    <= gnt_d ? (rd1 & ~wr1) : (rd0 & ~wr0);
                        busy      <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_ready || to_hit_d) begin
                        if (mem_rd) begin
                            if (owner) rdata1 <= ret_d;
                            else       rdata0 <= ret_d;
                        end
                        if (owner) ready1 <= 1'b1;
                        else       ready0 <= 1'b1;
                        if (!mem_ready) begin
                            timeout_err <= 1'b1;
                        end
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        prio_q  <= ~owner;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    ready0  <= 1'b0;
                    ready1  <= 1'b0;
                    busy    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing the single main-memory port (data_memory) between the instruction-cache and data-cache controller miss/write-back ports.
- Latches the winning request and drives the memory read/write command until memory reports ready.
- Returns a one-cycle ready plus read data to the owner only.
- Round-robin fairness, a bus-hang timeout, and a sticky error flag.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address width.
- TIMEOUT, 256, maximum BUSY cycles before abort; 0 disables the timeout.
- TO_WIDTH, 9, timeout counter width; must satisfy 2^TO_WIDTH > TIMEOUT.

Ports:
- clk  in  1  single clock, posedge.
- reset  in  1  asynchronous, active-low reset.
- rd0, wr0  in  1 each  requester 0 (I-cache) read/write request, level, held until ready0.
- addr0  in  ADDR_WIDTH  requester 0 address.
- wdata0  in  DATA_WIDTH  requester 0 write data.
- rdata0  out  DATA_WIDTH  requester 0 read data.
- ready0  out  1  requester 0 completion pulse.
- rd1, wr1, addr1, wdata1, rdata1, ready1  as above, for requester 1 (D-cache).
- mem_rd  out  1  read command to memory.
- mem_wr  out  1  write command to memory.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, one-cycle pulse.
- busy  out  1  transaction in flight (state != IDLE).
- owner  out  1  index of current or last granted requester.
- timeout_err  out  1  sticky timeout flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (reset=0, async): state=IDLE; prio=0; all outputs 0, including rdata0/1, owner, timeout_err and the counter.
- All outputs are registered; no combinational input-to-output paths.
- State IDLE:
  - reqN = rdN|wrN.
  - Only one reqN set: grant it.
  - Both set: grant the requester indicated by prio.
  - On grant: latch addrN, wdataN and op into mem_addr/mem_wdata/mem_rd/mem_wr; set owner; go BUSY.
  - Latency: request in cycle N gives mem command visible in cycle N+1.
- Op select: rdN&wrN together is treated as a write (mem_wr=1, mem_rd=0).
- State BUSY:
  - Hold the mem_* outputs stable; changes on requester inputs are ignored because they were latched at grant.
  - Counter increments each cycle.
  - On mem_ready:
    - Capture mem_rdata into rdata[owner] (read only; a write leaves rdata unchanged).
    - Assert ready[owner] next cycle.
    - Drop mem_rd/mem_wr; prio <= ~owner; go RELEASE.
  - Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT-1 without mem_ready, abort the same way.
    - rdata[owner] <= all ones (read only).
    - timeout_err <= 1.
- State RELEASE, exactly one cycle:
  - ready[owner]=1, other ready=0, mem_rd=mem_wr=0.
  - Go IDLE; the counter clears.
  - The owner must drop its request at the edge ending this cycle; IDLE then samples fresh requests. This prevents re-granting a completed request.
- readyN is 1 only in RELEASE and never asserts for both requesters in the same cycle.
- rdataN holds its value until that requester's next completed read.
- mem_ready outside BUSY is ignored.
- A mem_ready arriving in the same cycle the timeout fires counts as normal completion: no error, real data returned.
- err_clr clears timeout_err. If err_clr and a new timeout occur in the same cycle, set wins.
- Back-to-back throughput: 3 cycles minimum per transaction (IDLE→BUSY→RELEASE) when memory answers in the first BUSY cycle.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. Any in-flight memory access is abandoned; memory shares the same reset.

Test Plan:
- Single read: rd0=1, addr0=0x100; memory returns 0xDEADBEEF after 4 cycles → mem_rd=1 with mem_addr=0x100 from the cycle after the request; ready0 pulses 1 cycle; rdata0=0xDEADBEEF; ready1 stays 0.
- Simultaneous requests after reset: rd0 and wr1 (addr1=0x40, wdata1=0x55) both asserted → requester 0 served first (prio=0). Then mem_wr=1, mem_addr=0x40, mem_wdata=0x55, owner=1. Order 0,1,0,1 is sustained while both keep requesting.
- Request stability: change addr0 while in BUSY → mem_addr keeps the latched value until completion.
- Timeout: TIMEOUT=8, mem_ready never asserted → after 8 BUSY cycles ready0 pulses with rdata0=0xFFFFFFFF and timeout_err=1. err_clr=1 → timeout_err=0.
- Edge race: mem_ready in the final timeout cycle → normal completion, timeout_err stays 0. Also: rd1&wr1 together → write issued.
- Async reset: pull reset low mid-BUSY (between clock edges) → mem_rd, busy and ready outputs drop to 0 immediately; after release, the next request is granted normally from IDLE.
